// File: rtl/host_bypass_pkg.sv
// Shared definitions for the host bypass configuration block: register offsets,
// CTRL/STATUS bit positions, FSM encodings and a byte-strobe merge helper.
package host_bypass_pkg;

    localparam logic [11:0] REG_ID      = 12'h000;
    localparam logic [11:0] REG_CTRL    = 12'h004;
    localparam logic [11:0] REG_BASE_LO = 12'h008;
    localparam logic [11:0] REG_BASE_HI = 12'h00C;
    localparam logic [11:0] REG_STATUS  = 12'h010;

    localparam int CTRL_COMMIT_BIT    = 0;
    localparam int CTRL_ENABLE_BIT    = 1;
    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_XLAT_BIT    = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;
    localparam int STATUS_CNT_LSB     = 8;

    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_REQ  = 2'd1,
        CFG_WAIT = 2'd2
    } cfg_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/host_bypass_cfg_regs_axil_slave_if.sv
// AXI4-Lite slave front end: one-deep AW and W holds, registered B and R channels,
// presenting a simple word-aligned register write/read strobe interface.
module axil_slave_if
    import host_bypass_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i_n,
    input  logic [11:0] s_axil_awaddr,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [11:0] s_axil_araddr,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic        wr_en_o,
    output logic [11:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_strb_o,
    output logic        rd_en_o,
    output logic [11:0] rd_addr_o,
    input  logic [31:0] rd_data_i
);

    logic        aw_held_q, aw_held_d;
    logic [9:0]  awaddr_q, awaddr_d;
    logic        w_held_q, w_held_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        unused_addr_lsbs;

    // A transfer happens on any edge where valid & ready are both high; valid never
    // drops before that edge and ready never depends combinationally on valid.
    assign s_axil_awready = ~aw_held_q;
    assign s_axil_wready  = ~w_held_q;
    assign s_axil_arready = ~rvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;

    assign wr_en_o   = aw_held_q & w_held_q & ~bvalid_q;
    assign wr_addr_o = {awaddr_q, 2'b00};
    assign wr_data_o = wdata_q;
    assign wr_strb_o = wstrb_q;
    assign rd_en_o   = s_axil_arvalid & ~rvalid_q;
    assign rd_addr_o = {s_axil_araddr[11:2], 2'b00};

    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (wr_en_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end
        if (s_axil_awvalid && !aw_held_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axil_awaddr[11:2];
        end
        if (s_axil_wvalid && !w_held_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axil_wdata;
            wstrb_d  = s_axil_wstrb;
        end
        if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end
        if (rd_en_o) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_i;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i_n) begin
        if (!rst_i_n) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: rtl/host_bypass_cfg_regs.sv
// Host-facing control registers: stages a 64-bit RAM base, commits it to the
// translation init stage, tracks completion/timeout and gates the DMA path.
module host_bypass_cfg_regs
    import host_bypass_pkg::*;
#(
    parameter logic [31:0] ID_VALUE       = 32'h4842_0001,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          CNT_W          = 11
) (
    input  logic        clk_i,
    input  logic        rst_i_n,
    input  logic [11:0] s_axil_awaddr,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [11:0] s_axil_araddr,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic [63:0] ram_base_addr_o,
    output logic        init_o,
    input  logic        init_done_i,
    output logic        dma_enable_o
);

    logic        wr_en, rd_en;
    logic [11:0] wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic [3:0]  wr_strb;

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy, commit_wr, commit_go, done_hit, to_hit;

    logic        enable_q, enable_d, xlat_q, xlat_d, timeout_q, timeout_d, dma_q, dma_d;
    logic [31:0] base_lo_q, base_lo_d, base_hi_q, base_hi_d;
    logic [7:0]  commit_cnt_q, commit_cnt_d;
    logic [63:0] ram_base_q, ram_base_d;

    axil_slave_if u_axil (
        .clk_i, .rst_i_n,
        .s_axil_awaddr, .s_axil_awvalid, .s_axil_awready,
        .s_axil_wdata, .s_axil_wstrb, .s_axil_wvalid, .s_axil_wready,
        .s_axil_bresp, .s_axil_bvalid, .s_axil_bready,
        .s_axil_araddr, .s_axil_arvalid, .s_axil_arready,
        .s_axil_rdata, .s_axil_rresp, .s_axil_rvalid, .s_axil_rready,
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_strb_o(wr_strb),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data)
    );

    assign commit_wr = wr_en && (wr_addr == REG_CTRL) && wr_strb[0] && wr_data[CTRL_COMMIT_BIT];

    always_ff @(posedge clk_i or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state_q <= CFG_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Commits arriving outside IDLE are dropped; completion wins over a same-cycle timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit_go = 1'b0;
        done_hit  = 1'b0;
        to_hit    = 1'b0;
        case (state_q)
            CFG_IDLE: if (commit_wr) begin
                state_d   = CFG_REQ;
                commit_go = 1'b1;
            end
            CFG_REQ: begin
                state_d = CFG_WAIT;
                cnt_d   = '0;
            end
            CFG_WAIT: begin
                if (init_done_i) begin
                    state_d  = CFG_IDLE;
                    done_hit = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = CFG_IDLE;
                    to_hit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        init_o = (state_q == CFG_REQ);
        busy   = (state_q != CFG_IDLE);
    end

    always_comb begin
        enable_d     = enable_q;
        base_lo_d    = base_lo_q;
        base_hi_d    = base_hi_q;
        xlat_d       = xlat_q;
        timeout_d    = timeout_q;
        commit_cnt_d = commit_cnt_q;
        ram_base_d   = ram_base_q;
        dma_d        = enable_q & xlat_q;
        if (wr_en) begin
            case (wr_addr)
                REG_CTRL:    if (wr_strb[0]) enable_d = wr_data[CTRL_ENABLE_BIT];
                REG_BASE_LO: base_lo_d = apply_wstrb(base_lo_q, wr_data, wr_strb);
                REG_BASE_HI: base_hi_d = apply_wstrb(base_hi_q, wr_data, wr_strb);
                default: ;
            endcase
        end
        if (commit_go) begin
            ram_base_d   = {base_hi_q, base_lo_q};
            xlat_d       = 1'b0;
            timeout_d    = 1'b0;
            commit_cnt_d = commit_cnt_q + 8'd1;
        end
        if (done_hit) xlat_d = 1'b1;
        if (to_hit) timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i_n) begin
        if (!rst_i_n) begin
            enable_q     <= 1'b0;
            base_lo_q    <= '0;
            base_hi_q    <= '0;
            xlat_q       <= 1'b0;
            timeout_q    <= 1'b0;
            commit_cnt_q <= '0;
            ram_base_q   <= '0;
            dma_q        <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            base_lo_q    <= base_lo_d;
            base_hi_q    <= base_hi_d;
            xlat_q       <= xlat_d;
            timeout_q    <= timeout_d;
            commit_cnt_q <= commit_cnt_d;
            ram_base_q   <= ram_base_d;
            dma_q        <= dma_d;
        end
    end

    assign ram_base_addr_o = ram_base_q;
    assign dma_enable_o    = dma_q;

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (rd_addr)
                REG_ID:      rd_data = ID_VALUE;
                REG_CTRL:    rd_data[CTRL_ENABLE_BIT] = enable_q;
                REG_BASE_LO: rd_data = base_lo_q;
                REG_BASE_HI: rd_data = base_hi_q;
                REG_STATUS: begin
                    rd_data[STATUS_BUSY_BIT]       = busy;
                    rd_data[STATUS_XLAT_BIT]       = xlat_q;
                    rd_data[STATUS_TIMEOUT_BIT]    = timeout_q;
                    rd_data[STATUS_CNT_LSB +: 8]   = commit_cnt_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_bypass_cfg_regs.sv
// Directed bench for host_bypass_cfg_regs: register table sweep plus commit,
// decoupled AXI, timeout, busy-collision and async-reset sequences.
module tb_host_bypass_cfg_regs;

    logic        clk, rst_n;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [63:0] ram_base;
    logic        init_o, init_done, dma_en;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int init_cnt = 0;
    int init_cyc = 0;
    int b_cnt = 0;
    logic [63:0] init_addr = '0;

    host_bypass_cfg_regs dut (
        .clk_i(clk), .rst_i_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .ram_base_addr_o(ram_base), .init_o(init_o), .init_done_i(init_done),
        .dma_enable_o(dma_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (init_o) begin
            init_cnt  <= init_cnt + 1;
            init_cyc  <= cyc;
            init_addr <= ram_base;
        end
        if (bvalid && bready) b_cnt <= b_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int  n = 0;
        logic aw_hs, w_hs;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick(1);
            n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
        end
        while (!bvalid && n < 50) begin
            tick(1);
            n++;
        end
        check("bvalid_seen", 64'(bvalid), 64'd1);
        check("bresp_okay", 64'(bresp), 64'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        tick(1);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 50) begin
            tick(1);
            n++;
        end
        tick(1);
        arvalid = 1'b0;
        while (!rvalid && n < 50) begin
            tick(1);
            n++;
        end
        if (!rvalid) begin
            checks++;
            errors++;
            $display("FAIL read_timeout: addr 0x%0h no rvalid, required rvalid=1", a);
        end
        d = rdata;
        check("rresp_okay", 64'(rresp), 64'd0);
        tick(1);
    endtask

    task automatic pulse_done();
        init_done = 1'b1;
        tick(1);
        init_done = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int g = 0;
        while (cyc < target && g < 5000) begin
            tick(1);
            g++;
        end
        check("cycle_anchor", 64'(cyc), 64'(target));
    endtask

    typedef struct {
        logic [11:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [11:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        int i0;
        int b0;

        vecs[0]  = '{12'h008, 32'h1234_5678, 4'hF, 12'h008, 32'h1234_5678};
        vecs[1]  = '{12'h008, 32'hAABB_CCDD, 4'h1, 12'h008, 32'h1234_56DD};
        vecs[2]  = '{12'h008, 32'h00FF_0000, 4'h6, 12'h00B, 32'h12FF_00DD};
        vecs[3]  = '{12'h00C, 32'hA5A5_A5A5, 4'h8, 12'h00C, 32'hA500_0000};
        vecs[4]  = '{12'h00F, 32'h0000_0001, 4'hF, 12'h00C, 32'h0000_0001};
        vecs[5]  = '{12'h020, 32'hFFFF_FFFF, 4'hF, 12'h020, 32'h0000_0000};
        vecs[6]  = '{12'h000, 32'h0000_0000, 4'hF, 12'h000, 32'h4842_0001};
        vecs[7]  = '{12'h010, 32'hFFFF_FFFE, 4'hF, 12'h010, 32'h0000_0000};
        vecs[8]  = '{12'h004, 32'h0000_0002, 4'hF, 12'h004, 32'h0000_0002};
        vecs[9]  = '{12'h004, 32'h0000_0000, 4'hE, 12'h004, 32'h0000_0002};
        vecs[10] = '{12'h004, 32'h0000_0000, 4'h1, 12'h004, 32'h0000_0000};
        vecs[11] = '{12'hFFC, 32'h0000_1234, 4'hF, 12'hFFC, 32'h0000_0000};

        rst_n = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; init_done = 1'b0;
        tick(2);
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_wready", 64'(wready), 64'd1);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_ram_base", ram_base, 64'd0);
        check("rst_dma", 64'(dma_en), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        i0 = init_cnt;
        axi_read(12'h010, rd);
        check("reset_status", 64'(rd), 64'h0);
        axi_read(12'h000, rd);
        check("reset_id", 64'(rd), 64'h4842_0001);
        tick(100);
        check("reset_no_init", 64'(init_cnt - i0), 64'd0);

        // Register table sweep
        for (int k = 0; k < 12; k++) begin
            axi_write(vecs[k].wa, vecs[k].wd, vecs[k].ws);
            axi_read(vecs[k].ra, rd);
            check($sformatf("vec%0d", k), 64'(rd), 64'(vecs[k].exp));
        end
        check("table_no_init", 64'(init_cnt - i0), 64'd0);

        // Read and write to BASE_HI in the same cycle returns the old value
        awaddr = 12'h00C; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0; araddr = 12'h00C; arvalid = 1'b1;
        tick(1);
        arvalid = 1'b0;
        check("rw_same_cycle_old", 64'(rdata), 64'h1);
        check("rw_same_cycle_bvalid", 64'(bvalid), 64'd1);
        tick(1);
        axi_read(12'h00C, rd);
        check("rw_same_cycle_new", 64'(rd), 64'h77);

        // Program and commit
        reset_dut();
        i0 = init_cnt;
        axi_write(12'h008, 32'h0000_0000, 4'hF);
        axi_write(12'h00C, 32'h0000_0001, 4'hF);
        axi_write(12'h004, 32'h0000_0003, 4'hF);
        check("commit_one_pulse", 64'(init_cnt - i0), 64'd1);
        check("commit_init_addr", init_addr, 64'h1_0000_0000);
        check("commit_ram_base", ram_base, 64'h1_0000_0000);
        tick(18);
        pulse_done();
        check("dma_lag", 64'(dma_en), 64'd0);
        tick(1);
        check("dma_on", 64'(dma_en), 64'd1);
        axi_read(12'h010, rd);
        check("commit_status", 64'(rd), 64'h0102);
        axi_read(12'h004, rd);
        check("ctrl_commit_reads0", 64'(rd), 64'h2);
        check("commit_still_one", 64'(init_cnt - i0), 64'd1);
        axi_write(12'h004, 32'h0000_0000, 4'hF);
        check("dma_off", 64'(dma_en), 64'd0);

        // Decoupled AW/W with stalled bready
        reset_dut();
        b0 = b_cnt;
        bready = 1'b0; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick(1);
        wvalid = 1'b0;
        check("w_held_wready", 64'(wready), 64'd0);
        tick(4);
        awaddr = 12'h008; awvalid = 1'b1;
        tick(1);
        awvalid = 1'b0;
        tick(1);
        check("decoupled_bvalid", 64'(bvalid), 64'd1);
        tick(3);
        check("decoupled_bvalid_hold", 64'(bvalid), 64'd1);
        check("decoupled_bresp", 64'(bresp), 64'd0);
        bready = 1'b1;
        tick(1);
        check("decoupled_bvalid_clr", 64'(bvalid), 64'd0);
        tick(3);
        check("decoupled_one_resp", 64'(b_cnt - b0), 64'd1);
        axi_read(12'h008, rd);
        check("decoupled_data", 64'(rd), 64'hCAFE_F00D);

        // Timeout: BUSY spans the REQ cycle plus 1024 WAIT cycles
        reset_dut();
        axi_write(12'h004, 32'h0000_0003, 4'hF);
        wait_cyc(init_cyc + 1024);
        axi_read(12'h010, rd);
        check("timeout_last_busy", 64'(rd), 64'h0101);
        tick(4);
        axi_read(12'h010, rd);
        check("timeout_status", 64'(rd), 64'h0104);
        check("timeout_dma", 64'(dma_en), 64'd0);
        axi_write(12'h004, 32'h0000_0003, 4'hF);
        axi_read(12'h010, rd);
        check("recommit_clears_to", 64'(rd), 64'h0201);
        wait_cyc(init_cyc + 1025);
        axi_read(12'h010, rd);
        check("timeout_first_idle", 64'(rd), 64'h0204);
        check("timeout2_dma", 64'(dma_en), 64'd0);

        // Busy collisions
        reset_dut();
        pulse_done();
        axi_read(12'h010, rd);
        check("idle_done_ignored", 64'(rd), 64'h0);
        i0 = init_cnt;
        axi_write(12'h008, 32'h0000_1000, 4'hF);
        axi_write(12'h00C, 32'h0000_0002, 4'hF);
        axi_write(12'h004, 32'h0000_0001, 4'hF);
        check("busy_init_addr", init_addr, 64'h2_0000_1000);
        axi_write(12'h004, 32'h0000_0001, 4'hF);
        axi_write(12'h008, 32'hDEAD_BEEF, 4'hF);
        check("busy_no_second_pulse", 64'(init_cnt - i0), 64'd1);
        check("busy_ram_base_kept", ram_base, 64'h2_0000_1000);
        axi_read(12'h010, rd);
        check("busy_status", 64'(rd), 64'h0101);
        axi_read(12'h008, rd);
        check("busy_staging", 64'(rd), 64'hDEAD_BEEF);
        pulse_done();
        axi_read(12'h010, rd);
        check("busy_done_status", 64'(rd), 64'h0102);
        check("busy_ram_base_after", ram_base, 64'h2_0000_1000);

        // Async reset while waiting for completion
        reset_dut();
        axi_write(12'h008, 32'h0000_4000, 4'hF);
        axi_write(12'h004, 32'h0000_0003, 4'hF);
        tick(3);
        pulse_done();
        tick(2);
        check("pre_reset_dma", 64'(dma_en), 64'd1);
        axi_write(12'h004, 32'h0000_0003, 4'hF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_ram_base", ram_base, 64'd0);
        check("async_dma", 64'(dma_en), 64'd0);
        check("async_init", 64'(init_o), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        pulse_done();
        axi_read(12'h010, rd);
        check("async_status", 64'(rd), 64'h0);
        check("async_dma_after", 64'(dma_en), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
